sd_byte_fifo: RTL
=================

// Module: sd_byte_fifo
// PURPOSE
//  Byte-to-word elastic buffer directly downstream of the SD block-read stage.
//  Accepts the reader's byte stream (data/we, with busy back-pressure) and holds
//  at least one full 512-byte sector.
//  Presents little-endian 16-bit words to the consumer (audio/VGA fetch) over a
//  valid/ready handshake.
//  Flags dropped bytes and supports a synchronous flush between files.
// PARAMETERS
//  DEPTH_LOG2   9   storage depth = 2**DEPTH_LOG2 bytes (512 = one sector)
//  BUSY_MARGIN  4   wrBusy asserted when free bytes <= BUSY_MARGIN (covers writer in-flight bytes)
// PORTS
//  clk        in   1             system clock, all logic on posedge
//  reset      in   1             asynchronous, active-low; 0 = reset
//  flush      in   1             synchronous clear of contents/flags, active-high
//  wrData     in   8             byte from SD reader (foDataSent)
//  wrWe       in   1             write strobe, one byte per cycle high (foWe)
//  wrBusy     out  1             back-pressure to reader (foBusy)
//  rdData     out  16            {byte[n+1], byte[n]}; older byte in [7:0]
//  rdValid    out  1             >= 2 bytes stored
//  rdReady    in   1             consumer accepts rdData when rdValid & rdReady
//  overflow   out  1             sticky: a write arrived while full
//  empty      out  1             count == 0
// BEHAVIOUR
//  - State: wp, rp (DEPTH_LOG2 bits, wrap mod 2**DEPTH_LOG2); count (DEPTH_LOG2+1 bits,
//    0..DEPTH); overflow register. Memory: 2**DEPTH_LOG2 x 8, no reset.
//  - Reset (reset=0, async): wp=rp=0, count=0, overflow=0, so wrBusy=0, rdValid=0,
//    empty=1. rdData is don't-care while rdValid=0.
//  - Write: accepted iff wrWe & (count < DEPTH) using the pre-edge count.
//    An accepted write stores mem[wp]=wrData and advances wp+1.
//    wrWe & count==DEPTH: byte dropped, overflow<=1 next edge, pointers unchanged.
//  - Pop: rdValid & rdReady -> rp+=2 (wraps), 2 bytes removed. Show-ahead:
//    rdData = {mem[rp+1], mem[rp]} combinational from memory; index rp+1 wraps.
//  - count_next = count + accepted_write - 2*pop.
//    Simultaneous write+pop is legal; space freed by a pop is NOT usable for the
//    same-cycle write (full test uses pre-edge count).
//  - rdValid = (count >= 2). A single odd byte stays until its partner arrives or
//    flush is asserted. Write-to-rdValid latency: 1 cycle after the 2nd byte's
//    write edge.
//  - wrBusy = (DEPTH - count) <= BUSY_MARGIN, registered-count based (no
//    combinational path from wrWe).
//  - flush=1: next edge wp=rp=count=0, overflow=0. flush has priority over
//    same-cycle write and pop (both discarded).
//  - Reset mid-transfer: contents lost; the upstream reader is restarted by the
//    system. No partial-word recovery.
//  - Invariants: count <= DEPTH always; wp - rp == count mod DEPTH.
// CONFIGURATION
//  SD_BYTE_FIFO_STATS_EN defined:
//    - adds output level [DEPTH_LOG2:0] = count;
//    - adds output dropCount [15:0]: increments per dropped byte, saturates at
//      16'hFFFF, cleared by reset/flush.
//  SD_BYTE_FIFO_STATS_EN undefined: neither port exists; overflow flag only.
// TESTING
//  1 reset=0 then release, no stimulus -> empty=1, rdValid=0, wrBusy=0, overflow=0.
//  2 write 8'h34 then 8'h12, rdReady=0 -> rdValid=1 next cycle, rdData=16'h1234;
//    rdReady=1 for 1 cycle -> empty=1, rdValid=0.
//  3 write 512 bytes i[7:0], no reads -> wrBusy=1 from count 508; 513th byte
//    dropped, overflow=1; drain 256 words -> word k = {2k+1, 2k} mod 256.
//  4 fill to 511, then same cycle write + pop -> count=510, write accepted.
//    At count=512, same cycle write + pop -> count=510, byte dropped, overflow=1.
//  5 stream 1000 bytes with random rdReady and writer honouring wrBusy -> no
//    drops, output order exact across pointer wrap.
//  6 count=37 odd, overflow=1, assert flush with wrWe=1 -> empty=1, overflow=0,
//    byte discarded; with STATS_EN, dropCount=0.

Source files
------------

// File: rtl/sd_byte_fifo.sv
// Byte-in / little-endian-word-out elastic buffer behind the SD block reader.
// Optional SD_BYTE_FIFO_STATS_EN adds level and saturating dropCount outputs.
module sd_byte_fifo #(
    parameter int DEPTH_LOG2  = 9,
    parameter int BUSY_MARGIN = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [7:0]            wrData,
    input  logic                  wrWe,
    output logic                  wrBusy,
    output logic [15:0]           rdData,
    output logic                  rdValid,
    input  logic                  rdReady,
    output logic                  overflow,
`ifdef SD_BYTE_FIFO_STATS_EN
    output logic [DEPTH_LOG2:0]   level,
    output logic [15:0]           dropCount,
`endif
    output logic                  empty
);

    localparam int CW = DEPTH_LOG2 + 1;
    localparam logic [DEPTH_LOG2:0] DEPTH_C    = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] BUSY_LEVEL = DEPTH_C - CW'(BUSY_MARGIN);
    localparam logic [DEPTH_LOG2:0] TWO        = CW'(2);

    function automatic logic [15:0] satInc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [7:0]            mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wp, rp, rpPlus1;
    logic [DEPTH_LOG2:0]   count, countInc, countDec;
    logic                  overflowR;
    logic                  wrAccept, wrDrop, pop;

    // Full test uses the registered count, so a same-cycle pop never frees room for the write.
    assign wrAccept = wrWe && (count < DEPTH_C);
    assign wrDrop   = wrWe && (count == DEPTH_C);
    assign rdValid  = (count >= TWO);
    assign pop      = rdValid && rdReady;
    assign countInc = CW'(wrAccept);
    assign countDec = pop ? TWO : '0;

    assign rpPlus1  = rp + 1'b1;
    assign rdData   = {mem[rpPlus1], mem[rp]};
    assign wrBusy   = (count >= BUSY_LEVEL);
    assign empty    = (count == '0);
    assign overflow = overflowR;

    always_ff @(posedge clk) begin
        if (wrAccept && !flush) begin
            mem[wp] <= wrData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            overflowR <= 1'b0;
        end else if (flush) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            overflowR <= 1'b0;
        end else begin
            if (wrAccept) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + DEPTH_LOG2'(2);
            end
            count <= count + countInc - countDec;
            if (wrDrop) begin
                overflowR <= 1'b1;
            end
        end
    end

`ifdef SD_BYTE_FIFO_STATS_EN
    logic [15:0] dropCountR;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dropCountR <= '0;
        end else if (flush) begin
            dropCountR <= '0;
        end else if (wrDrop) begin
            dropCountR <= satInc(dropCountR);
        end
    end

    assign level     = count;
    assign dropCount = dropCountR;
`endif

endmodule
